// File: rtl/se_div_sched.sv
// Sequencer for the SE-block 16-lane channel-mean divider array: per group it reads
// 16 pooled sums, launches one shared-divisor divide and streams the quotients to FC1.
module se_div_sched #(
  parameter int WIDTH    = 14,
  parameter int FBITS    = 7,
  parameter int IN_WIDTH = 26,
  parameter int GRP_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [GRP_W-1:0]         cfg_groups,
  input  logic [IN_WIDTH-1:0]      cfg_divisor,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     sum_rd_en,
  output logic [GRP_W-1:0]         sum_rd_addr,
  input  logic [16*IN_WIDTH-1:0]   sum_rd_data,
  output logic                     div_start,
  output logic [16*IN_WIDTH-1:0]   div_dividends,
  output logic [IN_WIDTH-1:0]      div_divisor,
  input  logic                     div_done,
  input  logic [16*WIDTH-1:0]      div_results,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [16*WIDTH-1:0]      res_data,
  output logic [GRP_W-1:0]         res_group
);

  // state | meaning
  // IDLE  | waiting for go
  // RD    | sum buffer read strobe for group grp
  // LATCH | sum read data captured into dividend register
  // START | one-cycle divider start
  // WAIT  | divide in flight; first cycle ignores a stale done level
  // OUT   | quotient beat offered downstream
  // FIN   | done pulse (err too when divisor was zero)

  if (FBITS > WIDTH) begin : g_bad_fbits
    $error("FBITS must not exceed WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LATCH, S_START, S_WAIT, S_OUT, S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [GRP_W-1:0] grp;
  logic [GRP_W-1:0] grp_last;
  logic             err_flag;
  logic             wait_first;
  logic             cfg_ok;

  assign cfg_ok = (cfg_divisor != '0) && (cfg_groups != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    sum_rd_en   = 1'b0;
    sum_rd_addr = '0;
    div_start   = 1'b0;
    res_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = cfg_ok ? S_RD : S_FIN;
      end
      S_RD: begin
        busy        = 1'b1;
        sum_rd_en   = 1'b1;
        sum_rd_addr = grp;
        state_nxt   = S_LATCH;
      end
      S_LATCH: begin
        busy      = 1'b1;
        state_nxt = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        div_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (!wait_first && div_done) state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = (grp == grp_last) ? S_FIN : S_RD;
      end
      S_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        err       = err_flag;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider inputs only move in IDLE and LATCH, so they are frozen while a divide runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp           <= '0;
      grp_last      <= '0;
      err_flag      <= 1'b0;
      wait_first    <= 1'b0;
      div_dividends <= '0;
      div_divisor   <= '0;
      res_data      <= '0;
      res_group     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            err_flag <= (cfg_divisor == '0);
            grp      <= '0;
            if (cfg_ok) begin
              grp_last    <= cfg_groups - 1'b1;
              div_divisor <= cfg_divisor;
            end
          end
        end
        S_LATCH: div_dividends <= sum_rd_data;
        S_START: wait_first <= 1'b1;
        S_WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first && div_done) begin
            res_data  <= div_results;
            res_group <= grp;
          end
        end
        S_OUT: begin
          if (res_ready && (grp != grp_last)) grp <= grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_se_div_sched.sv
// Directed bench for se_div_sched with a sum-buffer model and a latency-4 Q7 divider
// model whose done level lingers one cycle past each start.
module tb_se_div_sched;

  localparam int WIDTH = 14;
  localparam int FBITS = 7;
  localparam int IN_WIDTH = 26;
  localparam int GRP_W = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   go;
  logic [GRP_W-1:0]       cfg_groups;
  logic [IN_WIDTH-1:0]    cfg_divisor;
  logic                   busy, done, err;
  logic                   sum_rd_en;
  logic [GRP_W-1:0]       sum_rd_addr;
  logic [16*IN_WIDTH-1:0] sum_rd_data;
  logic                   div_start;
  logic [16*IN_WIDTH-1:0] div_dividends;
  logic [IN_WIDTH-1:0]    div_divisor;
  logic                   div_done;
  logic [16*WIDTH-1:0]    div_results;
  logic                   res_valid;
  logic                   res_ready;
  logic [16*WIDTH-1:0]    res_data;
  logic [GRP_W-1:0]       res_group;

  int total = 0;
  int bad = 0;

  se_div_sched #(.WIDTH(WIDTH), .FBITS(FBITS), .IN_WIDTH(IN_WIDTH), .GRP_W(GRP_W)) dut (
    .clk(clk), .rst(rst), .go(go), .cfg_groups(cfg_groups), .cfg_divisor(cfg_divisor),
    .busy(busy), .done(done), .err(err),
    .sum_rd_en(sum_rd_en), .sum_rd_addr(sum_rd_addr), .sum_rd_data(sum_rd_data),
    .div_start(div_start), .div_dividends(div_dividends), .div_divisor(div_divisor),
    .div_done(div_done), .div_results(div_results),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_group(res_group)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*WIDTH-1:0] exp_res(input int g);
    logic [16*WIDTH-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      v = (g * 16 + k) << FBITS;
      r[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
    end
    return r;
  endfunction

  // Sum buffer: lane k of group g holds 49*(g*16+k), one-cycle read latency.
  always @(posedge clk) begin
    if (sum_rd_en)
      for (int k = 0; k < 16; k++)
        sum_rd_data[k*IN_WIDTH +: IN_WIDTH] <= IN_WIDTH'(49 * (int'(sum_rd_addr) * 16 + k));
  end

  // Divider array model: Q7 quotient, done 4 cycles after start, old done lingers a cycle.
  logic [3:0]             dcnt;
  logic [16*IN_WIDTH-1:0] ops;
  logic [IN_WIDTH-1:0]    ops_div;
  always @(posedge clk) begin
    if (rst) begin
      div_done    <= 1'b0;
      dcnt        <= '0;
      div_results <= '0;
    end else if (div_start) begin
      dcnt    <= 4'd4;
      ops     <= div_dividends;
      ops_div <= div_divisor;
    end else if (dcnt != 0) begin
      check("div_in_stable", {div_divisor, |(div_dividends ^ ops)}, {ops_div, 1'b0});
      dcnt <= dcnt - 1'b1;
      if (dcnt == 1) begin
        div_done <= 1'b1;
        for (int k = 0; k < 16; k++) begin
          longint q;
          q = (ops_div == 0) ? 0 : ((longint'(ops[k*IN_WIDTH +: IN_WIDTH]) << FBITS) / longint'(ops_div));
          div_results[k*WIDTH +: WIDTH] <= q[WIDTH-1:0];
        end
      end else begin
        div_done <= 1'b0;
      end
    end
  end

  task automatic run_op(input int groups, input int divisor, input int stall_g, input int stall_n,
                        input bit go_mid);
    int beat = 0, cyc = 0, nrd = 0, nst = 0, first_st = -1, last_x = -1;
    int stall_left, rd_snap = 0, st_snap = 0, exp_beats;
    logic [16*WIDTH-1:0] held = '0;
    logic [GRP_W-1:0] held_grp = '0;
    bit fin = 0;
    stall_left = stall_n;
    exp_beats = (divisor == 0) ? 0 : groups;
    cfg_groups  = GRP_W'(groups);
    cfg_divisor = IN_WIDTH'(divisor);
    res_ready = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", busy, 1'b1);
    while (!fin && cyc < 3000) begin
      if (sum_rd_en) nrd++;
      if (div_start) begin
        nst++;
        if (first_st < 0) first_st = cyc;
        if (beat > 0) check("xfer_to_start", cyc - last_x, 3);
      end
      if (done) fin = 1;
      else begin
        if (go_mid && cyc == 6) begin
          go = 1'b1; cfg_groups = 6'd1; cfg_divisor = '0;
        end else go = 1'b0;
        res_ready = 1'b1;
        if (res_valid) begin
          if (beat == stall_g && stall_left > 0) begin
            if (stall_left == stall_n) begin
              held = res_data; held_grp = res_group; rd_snap = nrd; st_snap = nst;
            end else begin
              check("stall_data", res_data, held);
              check("stall_group", res_group, held_grp);
            end
            res_ready = 1'b0;
            stall_left--;
          end else begin
            check("beat_group", res_group, beat);
            check("beat_data", res_data, exp_res(beat));
            if (beat == stall_g && stall_n > 0) begin
              check("stall_no_rd", nrd, rd_snap);
              check("stall_no_start", nst, st_snap);
            end
            beat++;
            last_x = cyc;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    go = 1'b0;
    res_ready = 1'b1;
    check("done_seen", fin, 1'b1);
    check("busy_at_done", busy, 1'b1);
    check("err_at_done", err, divisor == 0);
    check("beats", beat, exp_beats);
    check("rd_count", nrd, exp_beats);
    check("start_count", nst, exp_beats);
    if (exp_beats > 0) begin
      check("first_start_lat", first_st, 2);
      check("done_after_last", cyc - last_x, 1);
    end else begin
      check("done_lat", cyc, 0);
    end
    @(negedge clk);
    check("busy_idle", busy, 1'b0);
    check("done_pulse", {done, err}, 2'b00);
  endtask

  initial begin
    int cyc, nst;
    rst = 1'b1; go = 1'b0; res_ready = 1'b1; cfg_groups = '0; cfg_divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, err, sum_rd_en, sum_rd_addr, div_start, res_valid, res_group}, '0);
    check("rst_data", {|div_dividends, |div_divisor, |res_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3, 49, -1, 0, 1'b0);   // three groups, always ready
    run_op(3, 49, 1, 5, 1'b1);    // stall group 1, ignored go while busy; stale done at START
    run_op(4, 0, -1, 0, 1'b0);    // zero divisor
    run_op(0, 49, -1, 0, 1'b0);   // zero groups

    // Reset in the first WAIT cycle of group 1, then replay.
    cfg_groups = 6'd3; cfg_divisor = 26'd49; res_ready = 1'b1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 0; nst = 0;
    while (cyc < 200) begin
      if (div_start) nst++;
      if (nst == 2) break;
      @(negedge clk);
      cyc++;
    end
    check("reach_grp1_start", nst, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", {busy, done, err, sum_rd_en, sum_rd_addr, div_start, res_valid, res_group}, '0);
    check("midrst_data", {|div_dividends, |div_divisor, |res_data}, '0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_quiet", {busy, sum_rd_en, div_start, res_valid}, 4'b0);
    end
    run_op(3, 49, -1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
